// File: rtl/two_fifo_pkg.sv
// Shared definitions for the two-FIFO datapath.
//   dec_state_t : occupancy state of the return-path decrement stage
//   DATA_W_DEF  : default data word width
//   CNT_W_DEF   : default statistics counter width
package two_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready register slice.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_data/in_valid   : upstream payload and valid
//   in_ready           : registered ready, low only when both entries are full
//   out_data/out_valid : payload of the oldest held entry (main register)
//   out_ready          : downstream accepts
module skid_buf
  import two_fifo_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  dec_state_t   state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         valid_q;
  logic         ready_q;

  logic in_hs;
  logic out_hs;

  assign in_hs  = in_valid & ready_q;
  assign out_hs = valid_q & out_ready;

  // Ready is held low during reset and rises on the first edge after it,
  // so it is a registered function of the next state rather than of out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          ready_q <= 1'b1;
          if (in_hs) begin
            main_q  <= in_data;
            valid_q <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            main_q <= in_data;
          end else if (in_hs) begin
            skid_q  <= in_data;
            ready_q <= 1'b0;
            state_q <= TWO;
          end else if (out_hs) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (out_hs) begin
            main_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b0;
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = main_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/dec_stream.sv
// Streaming decrement stage on the return path: each accepted word leaves
// as data - 1 (wrapping, or clamped at 0 when SATURATE=1), with its last
// marker, through a two-entry skid buffer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_data/s_last/s_valid    : upstream word, end-of-packet, valid
//   s_ready                  : stage can accept (registered)
//   m_data/m_last/m_valid    : decremented word, its marker, valid
//   m_ready                  : downstream accepts
//   clr_cnt                  : synchronous clear of both counters
//   word_cnt                 : output handshakes, wraps
//   wrap_cnt                 : accepted words equal to zero, saturates
module dec_stream
  import two_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  wrap_cnt
);

  logic [DATA_W-1:0] dec_val;
  logic              is_zero;
  logic [DATA_W:0]   out_pl;
  logic              in_hs;
  logic              out_hs;

  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  wrap_cnt_q, wrap_cnt_d;

  assign is_zero = (s_data == '0);

  always_comb begin
    dec_val = s_data - DATA_W'(1);
    if (SATURATE && is_zero) begin
      dec_val = '0;
    end
  end

  skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_last, dec_val}),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .out_data  (out_pl),
    .out_valid (m_valid),
    .out_ready (m_ready)
  );

  assign m_data = out_pl[DATA_W-1:0];
  assign m_last = out_pl[DATA_W];

  assign in_hs  = s_valid & s_ready;
  assign out_hs = m_valid & m_ready;

  always_comb begin
    word_cnt_d = word_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    if (clr_cnt) begin
      word_cnt_d = '0;
      wrap_cnt_d = '0;
    end else begin
      if (out_hs) begin
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
      if (in_hs && is_zero && (wrap_cnt_q != '1)) begin
        wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
      wrap_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_dec_stream.sv
module tb_dec_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_data;
  logic        s_last, s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_last, m_valid, m_ready;
  logic        clr_cnt;
  logic [15:0] word_cnt, wrap_cnt;

  logic [7:0]  s2_data;
  logic        s2_last, s2_valid, s2_ready;
  logic [7:0]  m2_data;
  logic        m2_last, m2_valid, m2_ready;
  logic [15:0] word_cnt2, wrap_cnt2;

  dec_stream #(.DATA_W(8), .SATURATE(1'b0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .clr_cnt(clr_cnt), .word_cnt(word_cnt), .wrap_cnt(wrap_cnt)
  );

  dec_stream #(.DATA_W(8), .SATURATE(1'b1), .CNT_W(16)) dut_sat (
    .clk(clk), .rst(rst),
    .s_data(s2_data), .s_last(s2_last), .s_valid(s2_valid), .s_ready(s2_ready),
    .m_data(m2_data), .m_last(m2_last), .m_valid(m2_valid), .m_ready(m2_ready),
    .clr_cnt(1'b0), .word_cnt(word_cnt2), .wrap_cnt(wrap_cnt2)
  );

  int         errors = 0;
  int         checks = 0;
  int         hs_cnt = 0;
  logic [8:0] exp_q[$];
  bit         rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h with nothing expected at %0t", {m_last, m_data}, $time);
      end else begin
        chk("stream_word", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] e);
    int n;
    bit done;
    n = 0;
    done = 0;
    s_data = d;
    s_last = l;
    s_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back({l, e});
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word 0x%0h not accepted after %0d cycles", d, n);
        done = 1;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_data = 8'hAA; s_last = 1'b1; s_valid = 1'b1;
    m_ready = 1'b0; clr_cnt = 1'b0;
    s2_data = 8'h00; s2_last = 1'b0; s2_valid = 1'b0; m2_ready = 1'b1;
    rand_done = 0;

    // Reset state, s_valid ignored
    cycles(3);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 0);
    chk("rst_wrap_cnt", {16'd0, wrap_cnt}, 0);
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    cycles(1);
    chk("rel_s_ready", {31'd0, s_ready}, 1);
    chk("rel_m_valid", {31'd0, m_valid}, 0);

    // Back-to-back stream at full throughput
    send(8'h01, 1'b0, 8'h00);
    send(8'h02, 1'b0, 8'h01);
    send(8'h03, 1'b0, 8'h02);
    send(8'h10, 1'b0, 8'h0F);
    s_valid = 1'b0;
    chk("latency_pending", exp_q.size(), 1);
    cycles(1);
    chk("stream_drained", exp_q.size(), 0);
    chk("word_cnt_4", {16'd0, word_cnt}, 4);

    // Wrap-around with zero input
    send(8'h00, 1'b0, 8'hFF);
    send(8'h00, 1'b1, 8'hFF);
    s_valid = 1'b0;
    cycles(2);
    chk("wrap_cnt_2", {16'd0, wrap_cnt}, 2);
    chk("word_cnt_6", {16'd0, word_cnt}, 6);

    // Saturating instance
    chk("sat_s_ready", {31'd0, s2_ready}, 1);
    s2_data = 8'h00; s2_last = 1'b1; s2_valid = 1'b1;
    cycles(1);
    s2_valid = 1'b0;
    chk("sat_m_valid", {31'd0, m2_valid}, 1);
    chk("sat_m_data", {24'd0, m2_data}, 8'h00);
    chk("sat_m_last", {31'd0, m2_last}, 1);
    cycles(1);
    chk("sat_m_valid_done", {31'd0, m2_valid}, 0);
    chk("sat_wrap_cnt", {16'd0, wrap_cnt2}, 1);
    s2_data = 8'h05; s2_last = 1'b0; s2_valid = 1'b1;
    cycles(1);
    s2_valid = 1'b0;
    chk("sat_m_data_5", {24'd0, m2_data}, 8'h04);
    cycles(1);
    chk("sat_word_cnt", {16'd0, word_cnt2}, 2);
    chk("sat_wrap_cnt_hold", {16'd0, wrap_cnt2}, 1);

    // Back-pressure: two words absorbed, third held off
    m_ready = 1'b0;
    send(8'h05, 1'b0, 8'h04);
    send(8'h06, 1'b0, 8'h05);
    chk("bp_s_ready_low", {31'd0, s_ready}, 0);
    chk("bp_m_valid", {31'd0, m_valid}, 1);
    chk("bp_m_data", {24'd0, m_data}, 8'h04);
    s_data = 8'h07; s_last = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("bp_hold_ready", {31'd0, s_ready}, 0);
      chk("bp_hold_data", {24'd0, m_data}, 8'h04);
    end
    m_ready = 1'b1;
    send(8'h07, 1'b0, 8'h06);
    s_valid = 1'b0;
    cycles(3);
    chk("bp_drained", exp_q.size(), 0);

    // Random handshake toggling
    clr_cnt = 1'b1;
    cycles(1);
    clr_cnt = 1'b0;
    hs_cnt = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] d;
          logic       l;
          if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            cycles(1);
          end
          d = 8'($urandom_range(0, 255));
          l = 1'($urandom_range(0, 1));
          send(d, l, d - 8'd1);
        end
        s_valid = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycles(1);
    chk("rand_drained", exp_q.size(), 0);
    cycles(1);
    chk("rand_word_cnt", {16'd0, word_cnt}, {16'd0, hs_cnt[15:0]});

    // Reset while holding two words
    m_ready = 1'b0;
    send(8'h00, 1'b0, 8'hFF);
    send(8'h00, 1'b1, 8'hFF);
    s_valid = 1'b0;
    chk("two_s_ready", {31'd0, s_ready}, 0);
    rst = 1'b1;
    cycles(1);
    exp_q.delete();
    chk("midrst_m_valid", {31'd0, m_valid}, 0);
    chk("midrst_m_data", {24'd0, m_data}, 0);
    chk("midrst_word_cnt", {16'd0, word_cnt}, 0);
    chk("midrst_wrap_cnt", {16'd0, wrap_cnt}, 0);
    chk("midrst_s_ready", {31'd0, s_ready}, 0);
    rst = 1'b0;
    m_ready = 1'b1;
    cycles(1);
    chk("midrst_rel_ready", {31'd0, s_ready}, 1);
    chk("midrst_no_leftover", {31'd0, m_valid}, 0);

    // Clear coincident with input and output handshakes
    clr_cnt = 1'b1;
    send(8'h00, 1'b0, 8'hFF);
    s_valid = 1'b0;
    chk("clr_vs_wrap", {16'd0, wrap_cnt}, 0);
    cycles(1);
    clr_cnt = 1'b0;
    chk("clr_vs_word", {16'd0, word_cnt}, 0);
    send(8'h80, 1'b0, 8'h7F);
    s_valid = 1'b0;
    cycles(2);
    chk("post_clr_word", {16'd0, word_cnt}, 1);
    chk("post_clr_wrap", {16'd0, wrap_cnt}, 0);
    chk("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_stream.md
# dec_stream

Streaming decrement stage on the return path of the two-FIFO datapath. It is the inverse of the increment stage on the forward path: each accepted word leaves as `data - 1`. It has a valid/ready handshake on both sides, a two-entry skid buffer for full throughput under back-pressure, and two statistics counters. It sits between the output of the second FIFO and the downstream consumer.

## Interface
- `DATA_W`, default 8: data word width.
- `SATURATE`, default 0: 0 means `0 - 1` wraps to `2^DATA_W-1`; 1 means `0 - 1` clamps to 0.
- `CNT_W`, default 16: width of the statistics counters.

Clock and reset are one clock, `clk`, and reset `rst`, which is synchronous and active-high.
- `clk` input, 1: sole clock; all state changes on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `s_data` input, DATA_W: upstream word.
- `s_last` input, 1: upstream end-of-packet marker, carried alongside the data.
- `s_valid` input, 1: upstream word present.
- `s_ready` output, 1: stage can accept a word.
- `m_data` output, DATA_W: decremented word.
- `m_last` output, 1: `s_last` of that word.
- `m_valid` output, 1: output word present.
- `m_ready` input, 1: downstream accepts.
- `clr_cnt` input, 1: synchronous clear of both counters.
- `word_cnt` output, CNT_W: count of output handshakes; wraps modulo `2^CNT_W`.
- `wrap_cnt` output, CNT_W: count of accepted words with `s_data == 0`; saturates at all-ones.

## Operation
- An input handshake is `s_valid & s_ready`. An output handshake is `m_valid & m_ready`.
- Result: `m_data = s_data - 1`, truncated to DATA_W.
  - When `SATURATE=1` and `s_data == 0`, the result is 0.
  - `wrap_cnt` counts `s_data == 0` in both modes.
- `m_last` travels with its word unchanged.
- Words are never dropped, duplicated or reordered.
- Storage is a main output register plus one skid register. The state machine has three states:
  - EMPTY: no words held. `m_valid=0`, `s_ready=1`. An input handshake moves to ONE.
  - ONE: main register full, skid empty. `m_valid=1`, `s_ready=1`.
    - Input and output handshake together: stay in ONE, main register takes the new word.
    - Input handshake only: move to TWO, new word goes to skid.
    - Output handshake only: move to EMPTY.
  - TWO: both registers full. `m_valid=1`, `s_ready=0`. An output handshake moves the skid word into the main register and goes to ONE.
- `s_ready` is a register output, not a combinational path from `m_ready`.
- Counters:
  - When `clr_cnt` and a counting event occur in the same cycle, the counter ends at 0 (clear wins).
  - Counters are independent of the handshake state.
- Reset, with `rst` high at the clock edge:
  - state becomes EMPTY;
  - `m_valid=0`, `m_data=0`, `m_last=0`, `s_ready=0`, `word_cnt=0`, `wrap_cnt=0`;
  - `s_valid` is ignored.
- `s_ready` rises to 1 on the first edge with `rst` low.
- Reset mid-operation discards both held words, with no output handshake.

## Timing
- Latency: a word accepted at edge N is presented on `m_*` after edge N. It can be consumed at edge N+1 when `m_ready` is high.
- Throughput: one word per cycle whenever `m_ready` is held high.
- Back-pressure: at most two words are absorbed after `m_ready` falls. `s_ready` is low the cycle after the second word is accepted.
- Stability: while `m_valid=1` and `m_ready=0`, `m_data` and `m_last` hold their values.
- Counter values update on the edge of the triggering handshake and are visible the following cycle.

## Structure
- The shared package `two_fifo_pkg` holds:
  - the state enum `dec_state_t` (EMPTY, ONE, TWO);
  - the default width constants `DATA_W_DEF=8` and `CNT_W_DEF=16`.
- Sub-module `skid_buf`: generic 2-entry valid/ready register slice, parameterised by width.
  - The payload is `{last, data}`.
  - The top level computes the decremented value before `skid_buf` and owns the counters.

## Test plan
- Reset, then stream 1,2,3,0x10 with `m_ready=1`: outputs are 0,1,2,0x0F, one per cycle, first output one cycle after acceptance; `word_cnt=4`.
- With `SATURATE=0`, send 0x00 followed by 0x00 with `last=1`:
  - outputs are 0xFF and 0xFF with `m_last` on the second;
  - `wrap_cnt=2`.
- With `SATURATE=1`, send 0x00: output 0x00 and `wrap_cnt=1`.
- Hold `m_ready=0` while sending 5,6,7:
  - 5 and 6 are accepted and `s_ready` falls;
  - `m_data` holds 4;
  - release `m_ready`: outputs 4,5,6 in order, with no loss.
- Random `s_valid`/`m_ready` toggling over 1000 words, checked against a scoreboard:
  - order and values match;
  - `word_cnt` equals the number of output handshakes.
- Edge cases:
  - Assert `rst` while in TWO: the next cycle has `m_valid=0`, counters at 0, and `s_ready=1` one cycle after release.
  - `clr_cnt` coincident with a handshake leaves `word_cnt=0`.
